// File: rtl/arb_pkg.sv
// Shared types and constants for the register-sharing round-robin arbiter.
// State encodings, default sizing, and the hold-counter width helper.
package arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    localparam int DEF_N        = 4;
    localparam int DEF_W        = 8;
    localparam int DEF_HOLD_MAX = 15;

    // Width that can count from 0 up to max_val inclusive.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int HOLD_CNT_W = cnt_w(DEF_HOLD_MAX);

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority selector: first set req bit at or after ptr, searching upward mod N.
// Latency: purely combinational.
// Backpressure: none; pick is advisory and consumed only by the owning FSM.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic          vld
);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    always_comb begin
        pick = '0;
        vld  = 1'b0;
        sum  = '0;
        idx  = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(N))
                sum = sum - (PW+1)'(N);
            idx = sum[PW-1:0];
            if (!vld && req[idx]) begin
                pick[idx] = 1'b1;
                vld       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin owner of a shared W-bit register; optional eviction under ARB_TIMEOUT_EN.
// Latency: grant one edge after req, write lands one edge after wr, wr_ack the cycle after.
// Backpressure: non-owners simply wait in req; each release inserts one IDLE cycle.
module reg_share_arbiter
    import arb_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int W        = DEF_W,
    parameter int HOLD_MAX = DEF_HOLD_MAX
) (
    input  logic           clk,
    input  logic           res,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   wr,
    input  logic [N*W-1:0] din,
    output logic [N-1:0]   gnt,
    output logic [W-1:0]   q,
    output logic           busy,
    output logic           wr_ack
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    state_t        state;
    logic [PW-1:0] owner;
    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    logic [N-1:0]  pick;
    logic          pick_vld;
    logic [PW-1:0] pick_idx;
    logic          load_en;
    logic          timeout;
    logic [W-1:0]  din_arr [N];

    for (genvar g = 0; g < N; g++) begin : g_slice
        assign din_arr[g] = din[g*W +: W];
    end

    rr_pick #(.N(N), .PW(PW)) u_pick (
        .req  (req),
        .ptr  (ptr),
        .pick (pick),
        .vld  (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N; i++)
            if (pick[i])
                pick_idx = PW'(i);
    end

    assign ptr_nxt = (owner == PW'(N-1)) ? '0 : owner + 1'b1;
    assign load_en = (state == ST_OWN) && wr[owner];
    assign busy    = |gnt;

`ifdef ARB_TIMEOUT_EN
    localparam int HW = cnt_w(HOLD_MAX);
    logic [HW-1:0] hold_cnt;

    // Counts owned cycles; timeout fires on the edge closing the HOLD_MAX-th one.
    always_ff @(posedge clk) begin
        if (!res || state != ST_OWN)
            hold_cnt <= '0;
        else
            hold_cnt <= hold_cnt + 1'b1;
    end

    assign timeout = (state == ST_OWN) && (hold_cnt == HW'(HOLD_MAX - 1));
`else
    // Without the timeout build an owner keeps the grant for as long as it requests.
    assign timeout = (HOLD_MAX < 0);
`endif

    always_ff @(posedge clk) begin
        if (!res) begin
            state  <= ST_IDLE;
            gnt    <= '0;
            owner  <= '0;
            ptr    <= '0;
            wr_ack <= 1'b0;
        end else begin
            wr_ack <= load_en;
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        state <= ST_OWN;
                        gnt   <= pick;
                        owner <= pick_idx;
                    end
                end
                ST_OWN: begin
                    if (!req[owner] || timeout) begin
                        state <= ST_IDLE;
                        gnt   <= '0;
                        ptr   <= ptr_nxt;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

    // The shared bank: only the current owner's strobe can load it.
    always_ff @(posedge clk) begin
        if (!res)
            q <= '0;
        else if (load_en)
            q <= din_arr[owner];
    end

endmodule
